// File: rtl/lc3_pkg.sv
// -----------------------------------------------------------------------------
// lc3_pkg
// Shared definitions for the LC3 core pipeline stages (fetch, decode, execute).
//   LC3_AW / LC3_DW : default address and instruction widths
//   LC3_RESET_PC    : user-program origin loaded into the PC on reset
//   fetch_state_t   : instruction-fetch FSM encoding
// -----------------------------------------------------------------------------
package lc3_pkg;

    localparam int LC3_AW = 16;
    localparam int LC3_DW = 16;

    localparam logic [LC3_AW-1:0] LC3_RESET_PC = 16'h3000;

    // S_IDLE : no request outstanding, waiting for enable_fetch
    // S_REQ  : read strobe high, memory samples pc at the next edge
    // S_RESP : waiting to move the memory response into the decode buffer
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/lc3_fetch_if.sv
// -----------------------------------------------------------------------------
// lc3_fetch_if
// Bundles the two handshakes of the fetch stage:
//   instruction memory : pc, instrmem_rd (fetch -> mem)
//                        complete_instr, Instr_dout (mem -> fetch)
//   decode buffer      : ir, ir_pc, npc, ir_valid (fetch -> decode)
//                        ir_ready (decode -> fetch)
// master = fetch stage side, slave = memory/decode side.
// -----------------------------------------------------------------------------
interface lc3_fetch_if
    import lc3_pkg::*;
#(
    parameter int AW = LC3_AW,
    parameter int DW = LC3_DW
);

    // instruction memory port
    logic [AW-1:0] pc;
    logic          instrmem_rd;
    logic          complete_instr;
    logic [DW-1:0] Instr_dout;

    // decode-side valid/ready buffer
    logic [DW-1:0] ir;
    logic [AW-1:0] ir_pc;
    logic [AW-1:0] npc;
    logic          ir_valid;
    logic          ir_ready;

    modport master (
        output pc, instrmem_rd,
        input  complete_instr, Instr_dout,
        output ir, ir_pc, npc, ir_valid,
        input  ir_ready
    );

    modport slave (
        input  pc, instrmem_rd,
        output complete_instr, Instr_dout,
        input  ir, ir_pc, npc, ir_valid,
        output ir_ready
    );

endinterface

// File: rtl/lc3_fetch.sv
// -----------------------------------------------------------------------------
// lc3_fetch
// Instruction-fetch stage of the LC3 core. Owns the PC, issues one read per
// instruction to instruction memory and parks each returned word in a
// one-entry valid/ready buffer for decode. Execute can redirect the PC.
//
// Ports:
//   clock        : system clock, all state changes on posedge
//   reset        : synchronous active-high reset
//   enable_fetch : 1 = new memory requests may be issued, 0 = stall
//   br_taken     : one-cycle redirect pulse from execute
//   taddr        : redirect target, valid with br_taken
//   fbus         : memory + decode handshake (lc3_fetch_if.master)
//
// Parameters:
//   AW / DW  : address and instruction width
//   RESET_PC : PC value after reset
// -----------------------------------------------------------------------------
module lc3_fetch
    import lc3_pkg::*;
#(
    parameter int            AW       = LC3_AW,
    parameter int            DW       = LC3_DW,
    parameter logic [AW-1:0] RESET_PC = LC3_RESET_PC
)(
    input  logic          clock,
    input  logic          reset,
    input  logic          enable_fetch,
    input  logic          br_taken,
    input  logic [AW-1:0] taddr,
    lc3_fetch_if.master   fbus
);

    localparam logic [AW-1:0] PC_ONE = AW'(1);

    fetch_state_t  state_q, state_d;

    logic [AW-1:0] pc_q;
    logic [DW-1:0] ir_q;
    logic [AW-1:0] ir_pc_q;
    logic [AW-1:0] npc_q;
    logic          ir_valid_q;

    logic          buf_free;
    logic          capture;
    logic          rd;

    // -------------------------------------------------------------------------
    // Next-state and Moore output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d  = state_q;
        rd       = 1'b0;
        buf_free = !ir_valid_q || fbus.ir_ready;
        capture  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable_fetch) begin
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                rd      = 1'b1;
                state_d = S_RESP;
            end

            S_RESP: begin
                if (fbus.complete_instr) begin
                    if (buf_free) begin
                        capture = 1'b1;
                        state_d = enable_fetch ? S_REQ : S_IDLE;
                    end
                    // else: hold in S_RESP; memory keeps its output because
                    // no new read is issued, so the capture is retried.
                end else begin
                    // Response not ready: reissue the same address.
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A redirect discards whatever response is pending and outranks both
        // capture and the back-pressure stall.
        if (br_taken) begin
            capture = 1'b0;
            state_d = enable_fetch ? S_REQ : S_IDLE;
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // PC and decode buffer
    // Capture wins over the decode handshake, so a full buffer that is being
    // drained is refilled on the same edge with no bubble.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            npc_q      <= '0;
            ir_valid_q <= 1'b0;
        end else if (br_taken) begin
            pc_q       <= taddr;
            ir_valid_q <= 1'b0;
        end else if (capture) begin
            ir_q       <= fbus.Instr_dout;
            ir_pc_q    <= pc_q;
            npc_q      <= pc_q + PC_ONE;
            ir_valid_q <= 1'b1;
            pc_q       <= pc_q + PC_ONE;
        end else if (ir_valid_q && fbus.ir_ready) begin
            ir_valid_q <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign fbus.pc          = pc_q;
    assign fbus.instrmem_rd = rd;
    assign fbus.ir          = ir_q;
    assign fbus.ir_pc       = ir_pc_q;
    assign fbus.npc         = npc_q;
    assign fbus.ir_valid    = ir_valid_q;

endmodule

// File: tb/tb_lc3_fetch.sv
// -----------------------------------------------------------------------------
// tb_lc3_fetch
// Directed bench for lc3_fetch. Two instances share clock and control inputs:
// dut uses the default reset PC (3000), dut2 starts at FFFF to exercise PC
// wrap-around. Each instance sees a registered-read memory model that holds
// its output while no read is issued.
// -----------------------------------------------------------------------------
module tb_lc3_fetch;
    import lc3_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable_fetch;
    logic        br_taken;
    logic [15:0] taddr;
    logic        ir_ready;
    logic        force_incomplete;

    int total = 0;
    int bad   = 0;

    logic [15:0] ram [0:65535];

    lc3_fetch_if #(.AW(16), .DW(16)) bus1 ();
    lc3_fetch_if #(.AW(16), .DW(16)) bus2 ();

    lc3_fetch dut (
        .clock        (clock),
        .reset        (reset),
        .enable_fetch (enable_fetch),
        .br_taken     (br_taken),
        .taddr        (taddr),
        .fbus         (bus1)
    );

    lc3_fetch #(.RESET_PC(16'hFFFF)) dut2 (
        .clock        (clock),
        .reset        (reset),
        .enable_fetch (enable_fetch),
        .br_taken     (br_taken),
        .taddr        (taddr),
        .fbus         (bus2)
    );

    always #5 clock = ~clock;

    assign bus1.ir_ready = ir_ready;
    assign bus2.ir_ready = ir_ready;

    // Registered-read memory models
    always @(posedge clock) begin
        if (reset) begin
            bus1.complete_instr <= 1'b0;
            bus1.Instr_dout     <= 16'h0000;
        end else if (bus1.instrmem_rd) begin
            bus1.Instr_dout     <= ram[bus1.pc];
            bus1.complete_instr <= !force_incomplete;
        end
    end

    always @(posedge clock) begin
        if (reset) begin
            bus2.complete_instr <= 1'b0;
            bus2.Instr_dout     <= 16'h0000;
        end else if (bus2.instrmem_rd) begin
            bus2.Instr_dout     <= ram[bus2.pc];
            bus2.complete_instr <= 1'b1;
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) ram[a] = 16'h0000;
        ram[16'h3000] = 16'h1234;
        ram[16'h3001] = 16'h5678;
        ram[16'h3002] = 16'h9ABC;
        ram[16'h3003] = 16'hDEAD;
        ram[16'h4000] = 16'h4444;
        ram[16'hFFFF] = 16'hAAAA;
        ram[16'h0000] = 16'hBBBB;

        reset            = 1'b1;
        enable_fetch     = 1'b1;
        br_taken         = 1'b0;
        taddr            = 16'h0000;
        ir_ready         = 1'b1;
        force_incomplete = 1'b0;

        // ---- reset state ----
        step(2);
        check("rst_pc",       bus1.pc,          16'h3000);
        check("rst_rd",       bus1.instrmem_rd, 1'b0);
        check("rst_valid",    bus1.ir_valid,    1'b0);
        check("rst_ir",       bus1.ir,          16'h0000);
        check("rst_ir_pc",    bus1.ir_pc,       16'h0000);
        check("rst_npc",      bus1.npc,         16'h0000);
        check("rst_pc2",      bus2.pc,          16'hFFFF);

        // ---- basic fetch + wrap-around instance ----
        reset = 1'b0;
        step(1);
        check("t1_rd_e1",     bus1.instrmem_rd, 1'b1);
        check("t1_pc_e1",     bus1.pc,          16'h3000);
        step(1);
        check("t1_rd_e2",     bus1.instrmem_rd, 1'b0);
        check("t1_valid_e2",  bus1.ir_valid,    1'b0);
        step(1);
        check("t1_ir_e3",     bus1.ir,          16'h1234);
        check("t1_irpc_e3",   bus1.ir_pc,       16'h3000);
        check("t1_npc_e3",    bus1.npc,         16'h3001);
        check("t1_valid_e3",  bus1.ir_valid,    1'b1);
        check("t1_pc_e3",     bus1.pc,          16'h3001);
        check("t5_ir_e3",     bus2.ir,          16'hAAAA);
        check("t5_irpc_e3",   bus2.ir_pc,       16'hFFFF);
        check("t5_npc_e3",    bus2.npc,         16'h0000);
        check("t5_pc_e3",     bus2.pc,          16'h0000);
        step(2);
        check("t1_ir_e5",     bus1.ir,          16'h5678);
        check("t1_irpc_e5",   bus1.ir_pc,       16'h3001);
        check("t5_ir_e5",     bus2.ir,          16'hBBBB);
        check("t5_irpc_e5",   bus2.ir_pc,       16'h0000);
        check("t5_npc_e5",    bus2.npc,         16'h0001);

        // ---- back-pressure from decode ----
        reset = 1'b1;
        step(1);
        check("t2_rst_pc",    bus1.pc,          16'h3000);
        check("t2_rst_valid", bus1.ir_valid,    1'b0);
        reset = 1'b0;
        step(3);
        check("t2_ir_e3",     bus1.ir,          16'h1234);
        ir_ready = 1'b0;
        step(1);
        check("t2_rd_e4",     bus1.instrmem_rd, 1'b0);
        for (int k = 5; k <= 7; k++) begin
            step(1);
            check($sformatf("t2_ir_e%0d", k),    bus1.ir,          16'h1234);
            check($sformatf("t2_pc_e%0d", k),    bus1.pc,          16'h3001);
            check($sformatf("t2_rd_e%0d", k),    bus1.instrmem_rd, 1'b0);
            check($sformatf("t2_valid_e%0d", k), bus1.ir_valid,    1'b1);
        end
        ir_ready = 1'b1;
        step(1);
        check("t2_ir_e8",     bus1.ir,          16'h5678);
        check("t2_irpc_e8",   bus1.ir_pc,       16'h3001);
        check("t2_pc_e8",     bus1.pc,          16'h3002);

        // ---- incomplete responses reissue the same address ----
        force_incomplete = 1'b1;
        step(1);
        check("t3_rd_e9",     bus1.instrmem_rd, 1'b0);
        step(1);
        check("t3_rd_e10",    bus1.instrmem_rd, 1'b1);
        check("t3_pc_e10",    bus1.pc,          16'h3002);
        check("t3_ir_e10",    bus1.ir,          16'h5678);
        step(2);
        check("t3_rd_e12",    bus1.instrmem_rd, 1'b1);
        check("t3_pc_e12",    bus1.pc,          16'h3002);
        check("t3_ir_e12",    bus1.ir,          16'h5678);
        force_incomplete = 1'b0;
        step(2);
        check("t3_ir_e14",    bus1.ir,          16'h9ABC);
        check("t3_irpc_e14",  bus1.ir_pc,       16'h3002);
        check("t3_pc_e14",    bus1.pc,          16'h3003);

        // ---- redirect during S_RESP of 3003 ----
        ir_ready = 1'b0;
        step(1);
        check("t4_rd_e15",    bus1.instrmem_rd, 1'b0);
        check("t4_valid_e15", bus1.ir_valid,    1'b1);
        br_taken = 1'b1;
        taddr    = 16'h4000;
        step(1);
        check("t4_valid_e16", bus1.ir_valid,    1'b0);
        check("t4_pc_e16",    bus1.pc,          16'h4000);
        check("t4_ir_e16",    bus1.ir,          16'h9ABC);
        check("t4_rd_e16",    bus1.instrmem_rd, 1'b1);
        br_taken = 1'b0;
        ir_ready = 1'b1;
        step(2);
        check("t4_ir_e18",    bus1.ir,          16'h4444);
        check("t4_irpc_e18",  bus1.ir_pc,       16'h4000);
        check("t4_npc_e18",   bus1.npc,         16'h4001);
        check("t4_valid_e18", bus1.ir_valid,    1'b1);

        // ---- fetch disabled after one request, then reset in S_RESP ----
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(1);
        check("t6_rd_e1",     bus1.instrmem_rd, 1'b1);
        check("t6_pc_e1",     bus1.pc,          16'h3000);
        enable_fetch = 1'b0;
        step(2);
        check("t6_ir_e3",     bus1.ir,          16'h1234);
        check("t6_valid_e3",  bus1.ir_valid,    1'b1);
        check("t6_pc_e3",     bus1.pc,          16'h3001);
        check("t6_rd_e3",     bus1.instrmem_rd, 1'b0);
        step(1);
        check("t6_rd_e4",     bus1.instrmem_rd, 1'b0);
        check("t6_pc_e4",     bus1.pc,          16'h3001);
        enable_fetch = 1'b1;
        step(1);
        check("t6_rd_e5",     bus1.instrmem_rd, 1'b1);
        step(1);
        check("t6_rd_e6",     bus1.instrmem_rd, 1'b0);
        reset = 1'b1;
        step(1);
        check("t6_rst_pc",    bus1.pc,          16'h3000);
        check("t6_rst_valid", bus1.ir_valid,    1'b0);
        check("t6_rst_rd",    bus1.instrmem_rd, 1'b0);
        check("t6_rst_ir",    bus1.ir,          16'h0000);
        reset        = 1'b0;
        enable_fetch = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1);
            check($sformatf("t6_idle_rd_%0d", k), bus1.instrmem_rd, 1'b0);
            check($sformatf("t6_idle_pc_%0d", k), bus1.pc,          16'h3000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
